// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral
//   SPI mode-0 target exposing NUM_REGS registers of DATA_W bits. A frame is
//   1 R/W bit (1 = write), ADDR_W address bits and DATA_W data bits, MSB
//   first. Writes commit when nCS rises after exactly FRAME_W bits. Reads
//   shift the addressed register out on CIPO during the data phase.
//   Malformed frames and out-of-range addresses raise sticky flags and bump a
//   saturating error counter.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sclk, COPI, nCS   asynchronous SPI pins (synchronized internally)
//   CIPO, cipo_oe     registered target data out, output enable
//   regs              flattened register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_valid          one-cycle pulse on write commit
//   wr_addr, wr_data  last committed write
//   err_clr           clears frame_err, addr_err and err_cnt
//   frame_err         sticky: frame with wrong bit count
//   addr_err          sticky: frame addressed a missing register
//   err_cnt           rejected-frame count, saturating at 255
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic                       err_clr,
  output logic                       frame_err,
  output logic                       addr_err,
  output logic [7:0]                 err_cnt
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CMD_BITS = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(FRAME_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_FULL,
    ST_OVER
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  // Fills with ones after reset; the nCS chain is only trusted once the pin
  // has propagated through every stage and the delay flop, so a pin already
  // low at reset release does not look like a fresh nCS fall.
  logic [SYNC_STAGES:0]   flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      flush_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q & flush_q[SYNC_STAGES];
  assign ncs_rise  = ncs_s & ~ncs_dly_q;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]    tx_q, tx_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic                 wr_valid_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic                 cipo_q, cipo_d;
  logic                 frame_err_q, addr_err_q;
  logic [7:0]           err_cnt_q;

  logic                 commit, err_frame, err_addr;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS);
  endfunction

  // Fields of a complete frame held in the shift register.
  logic                 frame_rw;
  logic [ADDR_W-1:0]    frame_addr;
  logic [DATA_W-1:0]    frame_data;
  assign frame_rw   = shift_q[FRAME_W-1];
  assign frame_addr = shift_q[FRAME_W-2 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];

  // Command fields as they will stand after the last address bit is shifted
  // in, taken from the current register plus the incoming bit.
  logic                 cmd_rw;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [DATA_W-1:0]    rd_data;
  assign cmd_rw   = shift_q[ADDR_W-1];
  assign cmd_addr = {shift_q[ADDR_W-2:0], copi_s};

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ({{(32-ADDR_W){1'b0}}, cmd_addr} == i) rd_data = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    commit    = 1'b0;
    err_frame = 1'b0;
    err_addr  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (ncs_fall) begin
        state_d = ST_CMD;
        cnt_d   = '0;
        shift_d = '0;
        tx_d    = '0;
      end
    end else if (ncs_rise) begin
      state_d = ST_IDLE;
      tx_d    = '0;
      if (state_q == ST_FULL) begin
        if (!in_range(frame_addr)) err_addr = 1'b1;
        else if (frame_rw)         commit   = 1'b1;
      end else begin
        err_frame = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_CMD: begin
          if (sclk_rise) begin
            shift_d = {shift_q[FRAME_W-2:0], copi_s};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_d == CMD_BITS) begin
              state_d = ST_DATA;
              tx_d    = (!cmd_rw && in_range(cmd_addr)) ? rd_data : '0;
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shift_d = {shift_q[FRAME_W-2:0], copi_s};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_d == ALL_BITS) state_d = ST_FULL;
          end else if (sclk_fall && cnt_q != CMD_BITS) begin
            // The fall right after the last address bit must keep the MSB
            // in place for the controller's first data-bit sample.
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        ST_FULL: begin
          if (sclk_rise)      state_d = ST_OVER;
          else if (sclk_fall) tx_d    = {tx_q[DATA_W-2:0], 1'b0};
        end
        ST_OVER: begin
          if (sclk_fall) tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cipo_d = ~ncs_s & tx_d[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      regs_q      <= '{default: '0};
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cipo_q      <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      cipo_q     <= cipo_d;
      wr_valid_q <= commit;
      if (commit) begin
        wr_addr_q <= frame_addr;
        wr_data_q <= frame_data;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit && {{(32-ADDR_W){1'b0}}, frame_addr} == i) regs_q[i] <= frame_data;
      end
      if (err_clr) begin
        frame_err_q <= 1'b0;
        addr_err_q  <= 1'b0;
        err_cnt_q   <= '0;
      end else begin
        if (err_frame) frame_err_q <= 1'b1;
        if (err_addr)  addr_err_q  <= 1'b1;
        if ((err_frame || err_addr) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = ~ncs_s;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign addr_err  = addr_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: drives directed SPI frames into two
// instances (default parameters, and a 16x12-bit / 4-bit address / 3-stage
// variant) and compares their outputs every cycle with a frame-level model.
module tb_spi_regfile_peripheral;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sclk_p [2];
  logic copi_p [2];
  logic ncs_p  [2];
  logic clr_p  [2];

  logic         cipo0, oe0, wrv0, ferr0, aerr0;
  logic [39:0]  regs0;
  logic [6:0]   wra0;
  logic [7:0]   wrd0, ecnt0;
  logic         cipo1, oe1, wrv1, ferr1, aerr1;
  logic [191:0] regs1;
  logic [3:0]   wra1;
  logic [11:0]  wrd1;
  logic [7:0]   ecnt1;

  spi_regfile_peripheral #(
    .NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)
  ) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk_p[0]), .COPI(copi_p[0]), .nCS(ncs_p[0]),
    .CIPO(cipo0), .cipo_oe(oe0), .regs(regs0), .wr_valid(wrv0),
    .wr_addr(wra0), .wr_data(wrd0), .err_clr(clr_p[0]),
    .frame_err(ferr0), .addr_err(aerr0), .err_cnt(ecnt0)
  );

  spi_regfile_peripheral #(
    .NUM_REGS(16), .DATA_W(12), .ADDR_W(4), .SYNC_STAGES(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk_p[1]), .COPI(copi_p[1]), .nCS(ncs_p[1]),
    .CIPO(cipo1), .cipo_oe(oe1), .regs(regs1), .wr_valid(wrv1),
    .wr_addr(wra1), .wr_data(wrd1), .err_clr(clr_p[1]),
    .frame_err(ferr1), .addr_err(aerr1), .err_cnt(ecnt1)
  );

  int errors = 0;
  int checks = 0;

  // Per-instance configuration
  int nr [2] = '{5, 16};
  int aw [2] = '{7, 4};
  int dw [2] = '{8, 12};
  int ss [2] = '{2, 3};

  // Frame-level model state
  logic [11:0] m_regs [2][16];
  logic [6:0]  m_wra  [2];
  logic [11:0] m_wrd  [2];
  logic        m_wrv  [2];
  logic        m_ferr [2];
  logic        m_aerr [2];
  int          m_ecnt [2];
  logic        m_cchk [2];
  logic        m_cbit [2];
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) m_regs[s][i] = '0;
      m_wra[s] = '0; m_wrd[s] = '0; m_wrv[s] = 1'b0;
      m_ferr[s] = 1'b0; m_aerr[s] = 1'b0; m_ecnt[s] = 0;
      m_cchk[s] = 1'b0; m_cbit[s] = 1'b0;
    end
  endtask

  task automatic bump(input int sel);
    if (m_ecnt[sel] < 255) m_ecnt[sel]++;
  endtask

  function automatic logic [31:0] mk(input int sel, input int rw, input int addr, input int data);
    return 32'((rw << (aw[sel] + dw[sel])) | (addr << dw[sel]) | data);
  endfunction

  // Evaluate a finished frame of n bits (word w, first bit at w[n-1]).
  task automatic model_eval(input int sel, input logic [31:0] w, input int n);
    int fw, a;
    logic [11:0] d;
    fw = 1 + aw[sel] + dw[sel];
    if (n != fw) begin
      m_ferr[sel] = 1'b1;
      bump(sel);
    end else begin
      a = int'((w >> dw[sel]) & ((32'd1 << aw[sel]) - 1));
      d = 12'(w & ((32'd1 << dw[sel]) - 1));
      if (a >= nr[sel]) begin
        m_aerr[sel] = 1'b1;
        bump(sel);
      end else if (w[fw-1]) begin
        m_regs[sel][a] = d;
        m_wra[sel] = 7'(a);
        m_wrd[sel] = d;
        m_wrv[sel] = 1'b1;
      end
    end
  endtask

  // Send n bits of w; rst_at >= 0 pulses reset before that bit index, after
  // which the frame is expected to have no effect.
  task automatic frame(input int sel, input logic [31:0] w, input int n, input int rst_at);
    int s, h, fw, a;
    bit live, rd;
    logic [11:0] rdat;
    s = ss[sel]; h = s + 3; fw = 1 + aw[sel] + dw[sel]; live = 1'b1;
    rd = (w[n-1] == 1'b0);
    a = int'((w >> (n - 1 - aw[sel])) & ((32'd1 << aw[sel]) - 1));
    rdat = (rd && a < nr[sel]) ? m_regs[sel][a] : 12'h000;
    ncs_p[sel] = 1'b0;
    cyc(h);
    for (int b = 0; b < n; b++) begin
      if (b == rst_at) begin
        rst = 1'b1;
        cyc(1);
        model_reset();
        live = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
      end
      copi_p[sel] = w[n-1-b];
      cyc(h);
      sclk_p[sel] = 1'b1;
      if (live && b >= 1 + aw[sel] && b < fw) begin
        m_cbit[sel] = rdat[dw[sel] - 1 - (b - 1 - aw[sel])];
        m_cchk[sel] = 1'b1;
      end
      cyc(h);
      m_cchk[sel] = 1'b0;
      sclk_p[sel] = 1'b0;
    end
    cyc(h);
    ncs_p[sel] = 1'b1;
    cyc(s + 1);
    if (live) model_eval(sel, w, n);
    cyc(1);
    m_wrv[sel] = 1'b0;
    cyc(2);
  endtask

  task automatic clear_err(input int sel);
    clr_p[sel] = 1'b1;
    cyc(1);
    clr_p[sel] = 1'b0;
    m_ferr[sel] = 1'b0; m_aerr[sel] = 1'b0; m_ecnt[sel] = 0;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 5; i++) chk($sformatf("regs0[%0d]", i), regs0[i*8 +: 8], m_regs[0][i][7:0]);
      chk("wr_valid0", wrv0, m_wrv[0]);
      chk("wr_addr0", wra0, m_wra[0]);
      chk("wr_data0", wrd0, m_wrd[0][7:0]);
      chk("frame_err0", ferr0, m_ferr[0]);
      chk("addr_err0", aerr0, m_aerr[0]);
      chk("err_cnt0", ecnt0, m_ecnt[0]);
      if (m_cchk[0]) begin
        chk("CIPO0", cipo0, m_cbit[0]);
        chk("cipo_oe0", oe0, 1'b1);
      end
      for (int i = 0; i < 16; i++) chk($sformatf("regs1[%0d]", i), regs1[i*12 +: 12], m_regs[1][i]);
      chk("wr_valid1", wrv1, m_wrv[1]);
      chk("wr_addr1", wra1, m_wra[1]);
      chk("wr_data1", wrd1, m_wrd[1]);
      chk("frame_err1", ferr1, m_ferr[1]);
      chk("addr_err1", aerr1, m_aerr[1]);
      chk("err_cnt1", ecnt1, m_ecnt[1]);
      if (m_cchk[1]) begin
        chk("CIPO1", cipo1, m_cbit[1]);
        chk("cipo_oe1", oe1, 1'b1);
      end
    end
  end

  // Observers used by the literal checks: wr_valid pulse counts, CIPO as
  // sampled by the controller on sclk rise, cycles from nCS pin rise to commit.
  logic sclk0_w, sclk1_w;
  assign sclk0_w = sclk_p[0];
  assign sclk1_w = sclk_p[1];
  int pulses0 = 0, pulses1 = 0;
  int hc0 = 0, hc1 = 0, lat0 = 0, lat1 = 0;
  logic [15:0] cap0 = '0;
  logic [15:0] cap1 = '0;
  always @(posedge sclk0_w) cap0 = {cap0[14:0], cipo0};
  always @(posedge sclk1_w) cap1 = {cap1[14:0], cipo1};
  always @(posedge clk) begin
    hc0 = ncs_p[0] ? hc0 + 1 : 0;
    hc1 = ncs_p[1] ? hc1 + 1 : 0;
  end
  always @(negedge clk) begin
    if (wrv0) begin pulses0++; lat0 = hc0; end
    if (wrv1) begin pulses1++; lat1 = hc1; end
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sclk_p[s] = 1'b0; copi_p[s] = 1'b0; ncs_p[s] = 1'b1; clr_p[s] = 1'b0;
    end
    model_reset();
    cyc(4);
    chk("reset regs0", regs0, 40'h0);
    chk("reset regs1 zero", regs1 == '0, 1'b1);
    chk("reset CIPO0", cipo0, 1'b0);
    chk("reset cipo_oe0", oe0, 1'b0);
    chk("reset wr_valid1", wrv1, 1'b0);
    chk("reset err_cnt0", ecnt0, 8'h00);
    rst = 1'b0;
    cmp_en = 1'b1;
    cyc(10);

    // Write 0xAA to address 0
    frame(0, mk(0, 1, 0, 'hAA), 16, -1);
    chk("s1 regs0[7:0]", regs0[7:0], 8'hAA);
    chk("s1 wr_addr0", wra0, 7'd0);
    chk("s1 wr_data0", wrd0, 8'hAA);
    chk("s1 pulses0", pulses0, 1);
    chk("s1 latency0", lat0, 3);
    chk("s1 errs0", {ferr0, aerr0}, 2'b00);

    // Write 0x5C to address 4 and read it back
    frame(0, mk(0, 1, 4, 'h5C), 16, -1);
    frame(0, mk(0, 0, 4, 'h00), 16, -1);
    chk("s2 regs0[39:32]", regs0[39:32], 8'h5C);
    chk("s2 read bits0", cap0[7:0], 8'h5C);
    chk("s2 pulses0", pulses0, 2);

    // Out-of-range write, then out-of-range read
    frame(0, mk(0, 1, 5, 'h11), 16, -1);
    chk("s3 addr_err0", aerr0, 1'b1);
    chk("s3 err_cnt0", ecnt0, 8'd1);
    chk("s3 pulses0", pulses0, 2);
    chk("s3 regs0", regs0, 40'h5C_0000_00AA);
    frame(0, mk(0, 0, 6, 'h00), 16, -1);
    chk("s3 oob read bits0", cap0[7:0], 8'h00);
    chk("s3 err_cnt0 read", ecnt0, 8'd2);
    clear_err(0);

    // Short and long frames
    frame(0, 32'h0000_5555, 15, -1);
    frame(0, 32'h0001_AB55, 17, -1);
    chk("s4 frame_err0", ferr0, 1'b1);
    chk("s4 addr_err0", aerr0, 1'b0);
    chk("s4 err_cnt0", ecnt0, 8'd2);
    chk("s4 pulses0", pulses0, 2);
    clear_err(0);
    cyc(1);
    chk("s4 cleared0", {ferr0, aerr0, ecnt0}, 10'h000);

    // Reset in the middle of a write frame
    frame(0, mk(0, 1, 1, 'h77), 16, 8);
    chk("s5 regs0", regs0, 40'h0);
    chk("s5 pulses0", pulses0, 2);
    chk("s5 errs0", {ferr0, aerr0, ecnt0}, 10'h000);
    frame(0, mk(0, 1, 1, 'h3C), 16, -1);
    chk("s5 regs0 after", regs0, 40'h00_0000_3C00);
    chk("s5 pulses0 after", pulses0, 3);

    // Wider variant: 16 x 12-bit registers, 4-bit address, 3 sync stages
    frame(1, mk(1, 1, 0, 'hAAA), 17, -1);
    chk("s6 regs1[11:0]", regs1[11:0], 12'hAAA);
    chk("s6 wr_data1", wrd1, 12'hAAA);
    chk("s6 pulses1", pulses1, 1);
    chk("s6 latency1", lat1, 4);
    frame(1, mk(1, 1, 15, 'h5C3), 17, -1);
    frame(1, mk(1, 0, 15, 'h000), 17, -1);
    chk("s7 regs1[191:180]", regs1[191:180], 12'h5C3);
    chk("s7 wr_addr1", wra1, 4'd15);
    chk("s7 read bits1", cap1[11:0], 12'h5C3);
    chk("s7 pulses1", pulses1, 2);
    chk("s7 errs1", {ferr1, aerr1, ecnt1}, 10'h000);

    cyc(5);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
